// File: rtl/bk_mp_subtractor_if.sv
// Limb-stream bus for the multi-precision subtractor: operand limbs in, difference limbs and flags out.
interface bk_mp_subtractor_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;
  logic             out_borrow;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_first, in_last, a, b, out_ready,
    input  in_ready, out_valid, out_diff, out_last, out_idx, out_borrow, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_first, in_last, a, b, out_ready,
    output in_ready, out_valid, out_diff, out_last, out_idx, out_borrow, out_zero, out_err
  );
endinterface

// File: rtl/bk_mp_subtractor.sv
// Multi-precision subtractor/comparator: LS-limb-first stream, 16-bit Brent-Kung limb subtract,
// borrow chained between beats, running A<B and A==B flags.
module bk_mp_subtractor #(
  parameter int WIDTH = 16,  // prefix tree is built for 16 bits only
  parameter int IDX_W = 4
) (
  input logic              CLK,
  input logic              RST_N,
  bk_mp_subtractor_if.slave bus
);
  localparam int STAGES = 2;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic {IDLE, CHAIN} state_t;

  state_t           state, state_nxt;
  logic [STAGES:1]  vld_pipe;
  logic             en, xfer, start, bin;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_first, s1_last;
  logic             borrow_reg, zero_reg;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] g, p, gp, pp, diff;
  logic             borrow, zero_nxt, err_nxt;
  logic [IDX_W-1:0] idx_nxt;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign xfer         = en && vld_pipe[1];
  assign start        = (state == IDLE) || s1_first;
  assign bin          = start ? 1'b0 : borrow_reg;

  // a + ~b + ~bin through a Brent-Kung prefix; carry-in folded into bit 0's generate
  always_comb begin
    g  = s1_a & ~s1_b;
    p  = s1_a ^ ~s1_b;
    gp = g;
    pp = p;
    gp[0] = g[0] | (p[0] & ~bin);
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = (2 << lvl) - 1; i < WIDTH; i += (2 << lvl)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << lvl)]);
        pp[i] = pp[i] & pp[i - (1 << lvl)];
      end
    end
    for (int lvl = 2; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < WIDTH; i += (2 << lvl)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << lvl)]);
        pp[i] = pp[i] & pp[i - (1 << lvl)];
      end
    end
    diff   = p ^ {gp[WIDTH-2:0], ~bin};
    borrow = ~gp[WIDTH-1];
  end

  always_comb begin
    zero_nxt = (start || zero_reg) && (diff == '0);
    idx_nxt  = start ? '0 : ((idx == IDX_MAX) ? IDX_MAX : idx + 1'b1);
    // a first limb mid-chain abandons the old chain; a saturated index flags every extra limb
    err_nxt  = ((state == CHAIN) && s1_first) || (!start && (idx == IDX_MAX));
  end

  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = s1_last ? IDLE : CHAIN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe       <= '0;
      s1_a           <= '0;
      s1_b           <= '0;
      s1_first       <= 1'b0;
      s1_last        <= 1'b0;
      borrow_reg     <= 1'b0;
      zero_reg       <= 1'b1;
      idx            <= '0;
      bus.out_diff   <= '0;
      bus.out_last   <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_borrow <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_err    <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_first <= bus.in_first;
      s1_last  <= bus.in_last;
      if (vld_pipe[1]) begin
        bus.out_diff   <= diff;
        bus.out_last   <= s1_last;
        bus.out_idx    <= idx_nxt;
        bus.out_borrow <= borrow;
        bus.out_zero   <= zero_nxt;
        bus.out_err    <= err_nxt;
        borrow_reg     <= s1_last ? 1'b0 : borrow;
        zero_reg       <= s1_last ? 1'b1 : zero_nxt;
        idx            <= idx_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bk_mp_subtractor.sv
// Bench for bk_mp_subtractor: directed and random limb streams checked against a big-integer model.
module tb_bk_mp_subtractor;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  bk_mp_subtractor_if #(.WIDTH(16), .IDX_W(4)) bus ();
  bk_mp_subtractor #(.WIDTH(16), .IDX_W(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        last;
    logic [3:0]  idx;
    logic        err;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           last_wait = 0;
  bit           in_op = 1'b0;
  int           k = 0;
  logic [319:0] acc_a, acc_b;

  // Operands accumulate as whole integers; each limb's result comes from the prefix values.
  task automatic model_push(input logic [15:0] av, input logic [15:0] bv, input logic f, input logic l);
    beat_t        e;
    logic [319:0] d;
    bit           st;
    st    = !in_op || f;
    e.err = in_op && f;
    if (st) begin acc_a = '0; acc_b = '0; k = 0; end
    else if (k < 19) k++;
    acc_a[16*k +: 16] = av;
    acc_b[16*k +: 16] = bv;
    d        = acc_a - acc_b;
    e.diff   = d[16*k +: 16];
    e.borrow = acc_a < acc_b;
    e.zero   = acc_a == acc_b;
    e.last   = l;
    e.idx    = (k > 15) ? 4'd15 : 4'(k);
    e.err    = e.err || (k > 15);
    in_op    = !l;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    beat_t o, e;
    if (!RST_N) begin
      exp_q.delete();
      in_op = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        o = {bus.out_diff, bus.out_borrow, bus.out_zero, bus.out_last, bus.out_idx, bus.out_err};
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed diff=%h required no beat", o.diff);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (o === e) else begin
            errors++;
            $error("FAIL beat observed diff=%h b=%b z=%b l=%b i=%0d e=%b required diff=%h b=%b z=%b l=%b i=%0d e=%b",
                   o.diff, o.borrow, o.zero, o.last, o.idx, o.err,
                   e.diff, e.borrow, e.zero, e.last, e.idx, e.err);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) model_push(bus.a, bus.b, bus.in_first, bus.in_last);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic f, input logic l);
    int n;
    bit acc;
    bus.in_valid = 1'b1; bus.a = av; bus.b = bv; bus.in_first = f; bus.in_last = l;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge CLK); acc = bus.in_ready;
      @(posedge CLK); #1;
      n++;
    end
    last_wait = n;
    checks++;
    assert (acc === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout observed ready=%b required 1 within 200 cycles", acc);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(posedge CLK); #1; n++; end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  initial begin
    bit rdone;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    // reset state
    #2;
    chk("reset_outputs", 32'({bus.out_valid, bus.out_diff, bus.out_borrow, bus.out_zero,
                              bus.out_last, bus.out_idx, bus.out_err}), 32'd0);
    bus.out_ready = 1'b0;
    #1 chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    #10 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

    // single limb 5-3 with explicit 2-edge latency
    send(16'h0005, 16'h0003, 1'b1, 1'b1);
    @(negedge CLK);
    chk("latency_early", 32'(bus.out_valid), 32'd0);
    @(negedge CLK);
    chk("single_5_3", 32'({bus.out_valid, bus.out_diff, bus.out_borrow, bus.out_zero,
                           bus.out_last, bus.out_idx, bus.out_err}),
        32'({1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0}));
    @(posedge CLK); #1;

    send(16'h0000, 16'h0001, 1'b1, 1'b1);
    send(16'h0000, 16'h0001, 1'b1, 1'b0);
    send(16'h0001, 16'h0000, 1'b0, 1'b1);
    drain();

    // equal three-limb operands, then back-to-back next operation
    send(16'h9ABC, 16'h9ABC, 1'b1, 1'b0);
    send(16'h5678, 16'h5678, 1'b0, 1'b0);
    chk("no_bubble_1", 32'(last_wait), 32'd1);
    send(16'h1234, 16'h1234, 1'b0, 1'b1);
    send(16'h0007, 16'h0009, 1'b1, 1'b1);
    chk("no_bubble_2", 32'(last_wait), 32'd1);
    drain();

    // backpressure mid-chain with a borrow crossing the stall
    send(16'h0000, 16'h0001, 1'b1, 1'b0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 16'h0003; bus.b = 16'h0001; bus.in_first = 1'b0; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      if (exp_q.size() > 0) chk("stall_diff", 32'(bus.out_diff), 32'(exp_q[0].diff));
      @(posedge CLK); #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0003, 16'h0001, 1'b0, 1'b1);
    drain();

    // restart while chaining
    send(16'h000A, 16'h0003, 1'b1, 1'b0);
    send(16'h0004, 16'h0004, 1'b0, 1'b0);
    send(16'h0002, 16'h0005, 1'b1, 1'b1);
    drain();

    // index saturation over an 18-limb chain
    for (int i = 0; i < 18; i++) send(16'($urandom), 16'($urandom), i == 0, i == 17);
    drain();

    // asynchronous reset mid-chain
    send(16'h0001, 16'h0002, 1'b1, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0);
    #2 chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    RST_N = 1'b0;
    #1 chk("async_reset_outputs", 32'({bus.out_valid, bus.out_diff, bus.out_borrow, bus.out_zero,
                                       bus.out_last, bus.out_idx, bus.out_err}), 32'd0);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    send(16'h0008, 16'h0002, 1'b0, 1'b1);
    drain();

    // random operations under random backpressure
    rdone = 1'b0;
    fork
      begin
        for (int op = 0; op < 30; op++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom);
            send(ra, rb, (j == 0) && ($urandom_range(0, 5) != 0), j == len - 1);
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge CLK); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bk_mp_subtractor.md
Name: bk_mp_subtractor

Overview:
- Multi-precision subtractor and comparator: the inverse of the team's 16-bit Brent-Kung adder.
- Consumes operands A and B as a stream of 16-bit limbs, least-significant limb first, over a valid/ready interface.
- Computes each limb difference with a 16-bit Brent-Kung prefix tree (a + ~b + ~bin) and carries the borrow between beats.
- Emits difference limbs plus final borrow (A<B) and zero (A==B) flags; feeds the compare/normalise path downstream of the adder.

Parameters:
- WIDTH, 16, limb width; only 16 is supported because the prefix tree is fixed at 16 bits.
- IDX_W, 4, width of the limb-index counter; the counter saturates at 2^IDX_W-1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input limb valid.
- in_ready  output  1  block can accept a limb this cycle.
- in_first  input  1  limb is the least-significant limb of a new operand pair.
- in_last  input  1  limb is the most-significant limb of the operand pair.
- a  input  16  minuend limb.
- b  input  16  subtrahend limb.
- out_valid  output  1  output limb valid.
- out_ready  input  1  downstream accepts the output limb.
- out_diff  output  16  difference limb.
- out_last  output  1  output limb is the final limb of the operation.
- out_idx  output  IDX_W  limb index within the operation (0 = LS limb).
- out_borrow  output  1  borrow out of this limb; on the out_last beat it is the final A<B flag (unsigned).
- out_zero  output  1  running all-zero flag: 1 iff every diff limb so far in the operation is 0; on out_last it is A==B.
- out_err  output  1  protocol error on this beat (see rules).

Behaviour:
- Reset (async, RST_N=0): all outputs 0, s1/s2 valid cleared, borrow_reg=0, zero_reg=1, idx=0, state=IDLE. in_ready=1 after reset release.
- Pipeline: stage 1 registers a, b, first, last and valid. Stage 2 registers the computed diff and the flags. Global advance en = !out_valid | out_ready; in_ready = en.
- A limb accepted (in_valid & in_ready) at edge N appears on out_* after edge N+1. Latency is 2 edges; throughput is 1 limb/cycle with no stall.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and all s1/s2 registers, borrow_reg, zero_reg and idx hold.
- Limb arithmetic on the s1 limb moving to s2: bin = start ? 0 : borrow_reg.
  - diff = (a - b - bin) mod 2^16.
  - borrow = (a < b + bin), computed as the inverted carry-out of the Brent-Kung tree on (a, ~b, cin=~bin).
- start = state==IDLE | s1_first.
- State machine (advances on the s1->s2 transfer only):
  - IDLE, limb with last=0 -> CHAIN.
  - IDLE, last=1 -> IDLE (single-limb operation).
  - CHAIN, last=1 -> IDLE.
  - CHAIN, first=1 -> restart: treated as start, out_err=1 on that beat, and the previous chain is abandoned with no out_last emitted for it.
  - IDLE, first=0 -> accepted as start, out_err=0.
- borrow_reg <= last ? 0 : borrow.
- zero_reg <= last ? 1 : (start ? 1 : zero_reg) & (diff==0).
- out_zero = (start ? 1 : zero_reg) & (diff==0).
- idx: out_idx = start ? 0 : prior idx+1, saturating at 2^IDX_W-1. On saturation, out_err=1 on every further beat of that chain; arithmetic continues unaffected.
- out_last mirrors s1_last. first=last=1 gives a one-limb operation with borrow = a<b.
- Reset mid-operation discards all in-flight limbs. The next accepted limb starts a new operation regardless of in_first.
- Arithmetic is unsigned only; sign interpretation is the consumer's responsibility.

Test Plan:
- Single limb a=0x0005, b=0x0003, first=last=1 -> 2 edges later out_diff=0x0002, borrow=0, zero=0, last=1, idx=0, err=0.
- Single limb a=0x0000, b=0x0001 -> out_diff=0xFFFF, borrow=1, zero=0.
- Two limbs A=0x0001_0000, B=0x0000_0001 (beats {0x0000,0x0001}, {0x0001,0x0000}) -> beat0 diff=0xFFFF, borrow=1, idx=0; beat1 diff=0x0000, borrow=0, zero=0, last=1, idx=1.
- Equal three-limb operands 0x1234_5678_9ABC -> all diffs 0x0000, out_zero=1 on each beat, borrow=0 on the last beat; back-to-back next operation restarts idx=0 with no bubble.
- Backpressure: out_ready=0 for 3 cycles mid-chain -> out_* stable, in_ready=0, no limb lost; the chained borrow remains correct after release.
- Error/reset: in_first=1 while in CHAIN -> out_err=1, idx=0, bin=0 on that beat. Separately, RST_N pulsed low mid-chain -> outputs 0 immediately (asynchronously); the next limb is treated as start.
